// File: rtl/t5_decode.sv
// t5_decode: barrel-threaded RV32I decode stage with per-hart post-flush fetch kill.
module t5_decode #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned HW   = 2,
    parameter int unsigned KILL = 1
) (
    input  logic            sclk,
    input  logic            srst_n,
    input  logic            sena,
    input  logic            fvld,
    input  logic [XLEN-1:0] fpc,
    input  logic [31:0]     idat,
    input  logic [XLEN-1:0] rs1d,
    input  logic [XLEN-1:0] rs2d,
    input  logic            xflush,
    input  logic [HW-1:0]   xfhart,
    output logic [4:0]      rs1a,
    output logic [4:0]      rs2a,
    output logic            dvld,
    output logic            dill,
    output logic [HW-1:0]   dhart,
    output logic [XLEN-1:0] dop1,
    output logic [XLEN-1:0] dop2,
    output logic [XLEN-1:0] dcp1,
    output logic [XLEN-1:0] dcp2,
    output logic [4:0]      dopc,
    output logic [2:0]      dfn3,
    output logic [6:0]      dfn7,
    output logic [XLEN-1:0] dpc,
    output logic [XLEN-1:0] xpc,
    output logic [XLEN-1:0] mpc
);

    localparam int unsigned HARTS = 1 << HW;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
    localparam logic [4:0] OPC_NOP    = 5'h0D;

    logic [2:0]      r_kcnt [HARTS];
    logic            r_dvld;
    logic            r_dill;
    logic [HW-1:0]   r_dhart;
    logic [XLEN-1:0] r_dop1;
    logic [XLEN-1:0] r_dop2;
    logic [XLEN-1:0] r_dcp1;
    logic [XLEN-1:0] r_dcp2;
    logic [4:0]      r_dopc;
    logic [2:0]      r_dfn3;
    logic [6:0]      r_dfn7;
    logic [XLEN-1:0] r_dpc;
    logic [XLEN-1:0] r_xpc;
    logic [XLEN-1:0] r_mpc;

    logic [HW-1:0]   w_fhart;
    logic [4:0]      w_opc;
    logic            w_accept;
    logic            w_legal;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_pc_inc;

    assign w_fhart  = fpc[HW-1:0];
    assign w_opc    = idat[6:2];
    assign rs1a     = idat[19:15];
    assign rs2a     = idat[24:20];
    assign w_accept = sena & fvld & (r_kcnt[w_fhart] == 3'd0)
                      & ~(xflush & (xfhart == w_fhart));
    assign w_pc_inc = {fpc[XLEN-1:2] + (XLEN-2)'(1), fpc[1:0]};
    assign w_imm    = XLEN'($signed(w_imm32));

    // Legality check and format-dependent immediate extraction
    always_comb begin
        w_legal = 1'b0;
        w_imm32 = 32'd0;
        case (w_opc)
            OPC_LOAD, OPC_FENCE, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                w_legal = 1'b1;
                w_imm32 = {{20{idat[31]}}, idat[31:20]};
            end
            OPC_STORE: begin
                w_legal = 1'b1;
                w_imm32 = {{20{idat[31]}}, idat[31:25], idat[11:7]};
            end
            OPC_BRANCH: begin
                w_legal = 1'b1;
                w_imm32 = {{19{idat[31]}}, idat[31], idat[7], idat[30:25], idat[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                w_legal = 1'b1;
                w_imm32 = {idat[31:12], 12'd0};
            end
            OPC_JAL: begin
                w_legal = 1'b1;
                w_imm32 = {{11{idat[31]}}, idat[31], idat[19:12], idat[20], idat[30:21], 1'b0};
            end
            OPC_OP: begin
                w_legal = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        if (idat[1:0] != 2'b11) begin
            w_legal = 1'b0;
        end
    end

    // ALU operand selection; illegal instructions become a zero-operand NOP
    always_comb begin
        w_op1 = rs1d;
        w_op2 = w_imm;
        if ((w_opc == OPC_AUIPC) || (w_opc == OPC_BRANCH) || (w_opc == OPC_JAL)) begin
            w_op1 = fpc;
        end else if (w_opc == OPC_LUI) begin
            w_op1 = '0;
        end
        if (w_opc == OPC_OP) begin
            w_op2 = rs2d;
        end
        if (!w_legal) begin
            w_op1 = '0;
            w_op2 = '0;
        end
    end

    // Per-hart kill counters: flush reloads, dropped fetches count down
    always_ff @(posedge sclk) begin
        for (int unsigned h = 0; h < HARTS; h++) begin
            if (!srst_n) begin
                r_kcnt[h] <= 3'd0;
            end else if (xflush && (xfhart == HW'(h))) begin
                r_kcnt[h] <= 3'(KILL);
            end else if (sena && fvld && (w_fhart == HW'(h)) && (r_kcnt[h] != 3'd0)) begin
                r_kcnt[h] <= r_kcnt[h] - 3'd1;
            end
        end
    end

    // Decode valid: follows accept when advancing, flush can squash it while stalled
    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            r_dvld <= 1'b0;
        end else if (sena) begin
            r_dvld <= w_accept;
        end else if (xflush && r_dvld && (r_dhart == xfhart)) begin
            r_dvld <= 1'b0;
        end
    end

    // Decode payload registers, loaded only on accept
    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            r_dill  <= 1'b0;
            r_dhart <= '0;
            r_dop1  <= '0;
            r_dop2  <= '0;
            r_dcp1  <= '0;
            r_dcp2  <= '0;
            r_dopc  <= OPC_NOP;
            r_dfn3  <= 3'd0;
            r_dfn7  <= 7'd0;
        end else if (w_accept) begin
            r_dill  <= ~w_legal;
            r_dhart <= w_fhart;
            r_dop1  <= w_op1;
            r_dop2  <= w_op2;
            r_dcp1  <= rs1d;
            r_dcp2  <= rs2d;
            r_dopc  <= w_legal ? w_opc : OPC_NOP;
            r_dfn3  <= idat[14:12];
            r_dfn7  <= idat[31:25];
        end
    end

    // PC pipeline: link PC captured on accept, shifted toward execute/memory each advance
    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            r_dpc <= '0;
            r_xpc <= '0;
            r_mpc <= '0;
        end else if (sena) begin
            r_mpc <= r_xpc;
            r_xpc <= r_dpc;
            if (w_accept) begin
                r_dpc <= w_pc_inc;
            end
        end
    end

    assign dvld  = r_dvld;
    assign dill  = r_dill;
    assign dhart = r_dhart;
    assign dop1  = r_dop1;
    assign dop2  = r_dop2;
    assign dcp1  = r_dcp1;
    assign dcp2  = r_dcp2;
    assign dopc  = r_dopc;
    assign dfn3  = r_dfn3;
    assign dfn7  = r_dfn7;
    assign dpc   = r_dpc;
    assign xpc   = r_xpc;
    assign mpc   = r_mpc;

endmodule

// File: doc/t5_decode.md
T5_DECODE -- requirements
Module: t5_decode

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter HW, default 2, hart-id width; HARTS = 2^HW barrel-threaded harts.
REQ-003 Parameter KILL, default 1, fetch slots dropped per hart after a flush; range 0..7.
REQ-004 sclk  in  1  clock; all state updates on rising edge.
REQ-005 srst_n  in  1  reset; synchronous, active-low.
REQ-006 sena  in  1  pipeline advance enable; low = stall.
REQ-007 fvld  in  1  fetch slot valid.
REQ-008 fpc  in  XLEN  fetch PC; fpc[HW-1:0] carries hart id, fpc[XLEN-1:2] word address.
REQ-009 idat  in  32  fetched instruction.
REQ-010 rs1d, rs2d  in  XLEN  register-file read data for rs1a/rs2a.
REQ-011 xflush, xfhart  in  1, HW  flush request and target hart.
REQ-012 rs1a, rs2a  out  5  idat[19:15], idat[24:20]; combinational.
REQ-013 dvld, dill, dhart  out  1, 1, HW  decode valid, illegal flag, hart id.
REQ-014 dop1, dop2, dcp1, dcp2  out  XLEN  ALU operands and compare/store operands.
REQ-015 dopc, dfn3, dfn7  out  5, 3, 7  idat[6:2], idat[14:12], idat[31:25], registered.
REQ-016 dpc, xpc, mpc  out  XLEN  link PC and PC pipeline for execute/memory.

Function
REQ-017 Accept = sena & fvld & (kcnt[fpc[HW-1:0]] == 0) & !(xflush & xfhart == fpc[HW-1:0]).
REQ-018 With sena high, every edge: dvld <= accept; all other decode registers load only on accept.
REQ-019 With sena low, all registers hold, except REQ-023..REQ-025 flush effects.
REQ-020 Immediate: standard RV32I I/S/B/U/J formats, sign-extended from idat[31] to XLEN; R-type imm = 0.
REQ-021 dop1 = fpc for AUIPC/BRANCH/JAL, 0 for LUI, rs1d otherwise; dop2 = rs2d for OP (01100), imm otherwise.
REQ-022 dcp1 <= rs1d, dcp2 <= rs2d, dhart <= fpc[HW-1:0] on accept.
REQ-023 Per-hart 3-bit kill counter kcnt[h]; xflush loads kcnt[xfhart] <= KILL regardless of sena.
REQ-024 A fetch with fvld & sena for hart h with kcnt[h] != 0 is dropped and decrements kcnt[h]; never underflows.
REQ-025 xflush with dvld & dhart == xfhart clears dvld on that edge, including while stalled.
REQ-026 Simultaneous xflush and fetch of the same hart: fetch dropped, kcnt loads KILL (no decrement).
REQ-027 Flush of a hart different from the fetch hart does not affect the fetch.
REQ-028 dill <= 1 on accept when idat[1:0] != 2'b11 or dopc is not one of 00000,00011,00100,00101,01000,01100,01101,11000,11001,11011,11100; dvld stays 1.
REQ-029 On an illegal accept, dopc <= 5'h0D and dop1 = dop2 = 0, so execute sees a x0 NOP.
REQ-030 PC pipeline advances when sena high: mpc <= xpc, xpc <= dpc, dpc <= {fpc[XLEN-1:2]+1, fpc[1:0]} on accept; dpc holds on non-accept.
REQ-031 The PC increment wraps modulo 2^(XLEN-2) and preserves the hart bits.
REQ-032 Decode latency is one cycle from accept to dvld.

Reset
REQ-033 srst_n low at an edge: dvld, dill, dhart, dop1, dop2, dcp1, dcp2, dfn3, dfn7, dpc, xpc, mpc <= 0; dopc <= 5'h0D; all kcnt <= 0.
REQ-034 Reset has priority over sena, fvld and xflush; a reset mid-flush clears every pending kill.

Verification
REQ-035 ADDI x1,x2,-5 (0xFFB10093), fpc=0x100, rs1d=7, sena=fvld=1 -> next cycle: dvld=1, dop1=7, dop2=0xFFFFFFFB, dopc=5'h04, dpc=0x104.
REQ-036 BEQ with offset -8, fpc=0x201 (hart 1) -> dop1=0x201, dop2=0xFFFFFFF8, dhart=1, dpc=0x205.
REQ-037 KILL=2; xflush hart 2; then three hart-2 fetches -> first two dropped (dvld=0), third accepted; kcnt[2] ends at 0.
REQ-038 sena=0 for 3 cycles with dvld=1, dhart=3; xflush hart 3 in the 2nd cycle -> outputs hold, dvld clears, kcnt[3]=KILL.
REQ-039 idat=0x0000_0000 -> dill=1, dvld=1, dopc=5'h0D, dop1=dop2=0.
REQ-040 srst_n low during kcnt[0]=1 -> all outputs at reset values; the next hart-0 fetch is accepted.
